// File: rtl/reg_file_mp_if.sv
// reg_file_mp bus: read, write and reservation ports.
// The core drives the master side; the register file is the slave side.
interface reg_file_mp_if #(
  parameter int XLEN   = 32,
  parameter int DEPTH  = 32,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [NUM_RD*AW-1:0]   rd_addr;
  logic [NUM_RD*XLEN-1:0] rd_data;
  logic [NUM_RD-1:0]      rd_busy;
  logic [NUM_WR-1:0]      wr_en;
  logic [NUM_WR*AW-1:0]   wr_addr;
  logic [NUM_WR*XLEN-1:0] wr_data;
  logic                   rsv_en;
  logic [AW-1:0]          rsv_addr;
  logic [CW-1:0]          pend_cnt;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data,
    output rsv_en, rsv_addr,
    input  rd_data, rd_busy, pend_cnt
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data,
    input  rsv_en, rsv_addr,
    output rd_data, rd_busy, pend_cnt
  );
endinterface

// File: rtl/reg_file_mp.sv
// Multi-port integer register file with bypass, zero register
// and a per-register pending scoreboard for long-latency units.
module reg_file_mp #(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 32,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic         clk,
  input  logic         rst,
  reg_file_mp_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] regs [DEPTH];
  logic [DEPTH-1:0] pend;
  logic [DEPTH-1:0] pend_nxt;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;

  logic [AW-1:0]    wa [NUM_WR];
  logic [XLEN-1:0]  wd [NUM_WR];
  logic [NUM_WR-1:0] we;
  logic             rv;
  logic [DEPTH-1:0] wr_mask;
  logic [DEPTH-1:0] rsv_mask;
  logic [DEPTH-1:0] clr_mask;

  logic [NUM_RD*XLEN-1:0] rdat;
  logic [NUM_RD-1:0]      busy;

  // Address 0 (when hardwired) and out-of-range addresses are never stored.
  function automatic logic valid_addr(logic [AW-1:0] a);
    return (int'(a) < DEPTH) && !(ZERO_REG != 0 && a == '0);
  endfunction

  always_comb begin
    we       = '0;
    wr_mask  = '0;
    rsv_mask = '0;
    for (int j = 0; j < NUM_WR; j++) begin
      wa[j] = bus.wr_addr[j*AW +: AW];
      wd[j] = bus.wr_data[j*XLEN +: XLEN];
      we[j] = bus.wr_en[j] && valid_addr(wa[j]);
      if (we[j]) wr_mask[wa[j]] = 1'b1;
    end
    rv = bus.rsv_en && valid_addr(bus.rsv_addr);
    if (rv) rsv_mask[bus.rsv_addr] = 1'b1;
  end

  // A same-cycle reservation wins over a write clear.
  always_comb begin
    pend_nxt = (pend & ~wr_mask) | rsv_mask;
    clr_mask = pend & wr_mask & ~rsv_mask;
    cnt_nxt  = cnt
             + CW'(|(rsv_mask & ~pend))
             - CW'($countones(clr_mask));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) regs[r] <= '0;
      pend <= '0;
      cnt  <= '0;
    end else begin
      for (int j = 0; j < NUM_WR; j++)
        if (we[j]) regs[wa[j]] <= wd[j];
      pend <= pend_nxt;
      cnt  <= cnt_nxt;
    end
  end

  always_comb begin
    rdat = '0;
    busy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      logic [AW-1:0] ra;
      ra = bus.rd_addr[i*AW +: AW];
      if (valid_addr(ra)) begin
        rdat[i*XLEN +: XLEN] = regs[ra];
        busy[i]              = pend[ra];
        // Ascending scan: the higher-index write port wins.
        for (int j = 0; j < NUM_WR; j++) begin
          if (BYPASS != 0 && we[j] && wa[j] == ra) begin
            rdat[i*XLEN +: XLEN] = wd[j];
            busy[i]              = 1'b0;
          end
        end
      end
    end
  end

  assign bus.rd_data  = rdat;
  assign bus.rd_busy  = busy;
  assign bus.pend_cnt = cnt;
endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: bypass on/off and DEPTH=24
// instances share one stimulus stream.
module tb_reg_file_mp;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic        rsv_en;
  logic [4:0]  rsv_addr;
  logic [9:0]  rd_addr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_file_mp_if #(.DEPTH(32)) b0 ();
  reg_file_mp_if #(.DEPTH(32)) b1 ();
  reg_file_mp_if #(.DEPTH(24)) b2 ();

  assign b0.wr_en = wr_en;     assign b1.wr_en = wr_en;     assign b2.wr_en = wr_en;
  assign b0.wr_addr = wr_addr; assign b1.wr_addr = wr_addr; assign b2.wr_addr = wr_addr;
  assign b0.wr_data = wr_data; assign b1.wr_data = wr_data; assign b2.wr_data = wr_data;
  assign b0.rsv_en = rsv_en;   assign b1.rsv_en = rsv_en;   assign b2.rsv_en = rsv_en;
  assign b0.rsv_addr = rsv_addr;
  assign b1.rsv_addr = rsv_addr;
  assign b2.rsv_addr = rsv_addr;
  assign b0.rd_addr = rd_addr; assign b1.rd_addr = rd_addr; assign b2.rd_addr = rd_addr;

  reg_file_mp #(.DEPTH(32), .BYPASS(1)) u_byp (
    .clk(clk), .rst(rst), .bus(b0.slave));
  reg_file_mp #(.DEPTH(32), .BYPASS(0)) u_nobyp (
    .clk(clk), .rst(rst), .bus(b1.slave));
  reg_file_mp #(.DEPTH(24), .BYPASS(1)) u_d24 (
    .clk(clk), .rst(rst), .bus(b2.slave));

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en  = '0;
    rsv_en = 1'b0;
  endtask

  task automatic wr(logic [1:0] en, logic [4:0] a0, logic [31:0] d0,
                    logic [4:0] a1, logic [31:0] d1);
    wr_en   = en;
    wr_addr = {a1, a0};
    wr_data = {d1, d0};
  endtask

  task automatic rsv(logic [4:0] a);
    rsv_en   = 1'b1;
    rsv_addr = a;
  endtask

  task automatic rd(logic [4:0] a0, logic [4:0] a1);
    rd_addr = {a1, a0};
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    wr_addr = '0; wr_data = '0; rsv_addr = '0; rd_addr = '0;
    tick(); tick();
    rst = 1'b0;

    rd(0, 5);
    chk("rst_x0", b0.rd_data[31:0], 0);
    chk("rst_busy", b0.rd_busy, 0);
    chk("rst_cnt", b0.pend_cnt, 0);

    wr(2'b11, 0, 32'hDEADBEEF, 5, 32'hDEADBEEF);
    rd(0, 5);
    chk("x0_byp", b0.rd_data[31:0], 0);
    chk("x5_byp", b0.rd_data[63:32], 32'hDEADBEEF);
    tick(); idle(); rd(0, 5);
    chk("x0_st", b0.rd_data[31:0], 0);
    chk("x5_st", b0.rd_data[63:32], 32'hDEADBEEF);
    rst = 1'b1; tick(); rst = 1'b0; rd(0, 5);
    chk("x0_post", b0.rd_data[31:0], 0);
    chk("x5_post", b0.rd_data[63:32], 0);
    chk("cnt_post", b0.pend_cnt, 0);

    wr(2'b11, 7, 32'h11111111, 7, 32'h22222222);
    rd(7, 0);
    chk("col_byp", b0.rd_data[31:0], 32'h22222222);
    chk("col_nobyp", b1.rd_data[31:0], 0);
    tick(); idle(); rd(7, 0);
    chk("col_st", b0.rd_data[31:0], 32'h22222222);
    chk("col_st_nb", b1.rd_data[31:0], 32'h22222222);

    wr(2'b01, 3, 32'hA, 0, 0);
    tick();
    wr(2'b01, 3, 32'hB, 0, 0);
    rd(3, 0);
    chk("x3_nobyp", b1.rd_data[31:0], 32'hA);
    chk("x3_byp", b0.rd_data[31:0], 32'hB);
    tick(); idle(); rd(3, 0);
    chk("x3_nb_nxt", b1.rd_data[31:0], 32'hB);
    chk("x3_b_nxt", b0.rd_data[31:0], 32'hB);

    rsv(4); tick(); rd(4, 9);
    chk("cnt_1", b0.pend_cnt, 1);
    rsv(9); tick(); rd(4, 9);
    chk("cnt_2", b0.pend_cnt, 2);
    rsv(9); tick(); idle(); rd(4, 9);
    chk("cnt_2b", b0.pend_cnt, 2);
    chk("busy_49", b0.rd_busy, 2'b11);
    chk("busy_49_nb", b1.rd_busy, 2'b11);
    wr(2'b11, 4, 32'h44, 9, 32'h99);
    rd(4, 9);
    chk("busy_byp", b0.rd_busy, 2'b00);
    chk("busy_nobyp", b1.rd_busy, 2'b11);
    tick(); idle(); rd(4, 9);
    chk("cnt_0", b0.pend_cnt, 0);
    chk("cnt_0_nb", b1.pend_cnt, 0);
    chk("busy_clr", b1.rd_busy, 2'b00);

    rsv(4); tick(); rsv(9); tick(); idle();
    wr(2'b11, 9, 32'h1, 9, 32'h2);
    tick(); idle(); rd(4, 9);
    chk("dup_clr_cnt", b0.pend_cnt, 1);
    chk("dup_clr_busy", b0.rd_busy, 2'b01);
    chk("dup_clr_dat", b0.rd_data[63:32], 32'h2);
    wr(2'b01, 4, 0, 0, 0); tick(); idle();

    rsv(6); tick(); idle(); rd(6, 0);
    chk("x6_cnt1", b0.pend_cnt, 1);
    rsv(6); wr(2'b01, 6, 32'h66, 0, 0);
    tick(); idle(); rd(6, 0);
    chk("sc_dat", b1.rd_data[31:0], 32'h66);
    chk("sc_busy", b1.rd_busy[0], 1);
    chk("sc_cnt", b0.pend_cnt, 1);
    wr(2'b01, 6, 32'h67, 0, 0); tick(); idle(); rd(6, 0);
    chk("sc_clr", b0.pend_cnt, 0);

    wr(2'b01, 30, 32'h30, 0, 0); rsv(30);
    rd(30, 0);
    chk("oor_byp", b2.rd_data[31:0], 0);
    chk("oor_busy0", b2.rd_busy[0], 0);
    tick(); idle(); rd(30, 0);
    chk("oor_dat", b2.rd_data[31:0], 0);
    chk("oor_busy", b2.rd_busy[0], 0);
    chk("oor_cnt", b2.pend_cnt, 0);
    chk("x30_d32", b0.rd_data[31:0], 32'h30);
    chk("x30_cnt", b0.pend_cnt, 1);

    rsv(2); rst = 1'b1;
    tick(); rst = 1'b0; idle(); rd(2, 30);
    chk("rr_busy", b0.rd_busy, 2'b00);
    chk("rr_cnt", b0.pend_cnt, 0);
    chk("rr_x30", b0.rd_data[63:32], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
